zx_video_sequencer: RTL and testbench

- Generates Pentagon-style raster timing: 448 pixel clocks per line, 320 lines per frame.
- Sequences the video memory fetch strobes that feed the downstream pixel/attribute latch-and-shift stage: pixel latch, attribute latch, shifter load, attribute transfer.
- Produces blank, sync, border-select, flash and the Z80 frame interrupt.
- Arbitrates the single video RAM port between video fetch (fixed priority) and CPU.

---
 rtl/zx_video_sequencer_pkg.sv | 60 ++++++
 rtl/zx_video_sequencer_if.sv | 28 ++
 rtl/zx_video_sequencer_raster_counter.sv | 44 ++++
 rtl/zx_video_sequencer.sv | 123 ++++++++++++
 tb/tb_zx_video_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/zx_video_sequencer_pkg.sv
// Shared raster geometry, fetch phases and VRAM address helpers for the
// Pentagon-style video sequencer.
package zx_video_pkg;

    localparam int H_TOTAL  = 448;
    localparam int V_TOTAL  = 320;
    localparam int INT_LINE = 239;
    localparam int INT_LEN  = 32;

    localparam logic [8:0] H_FETCH_END = 9'd256;
    localparam logic [8:0] V_FETCH_END = 9'd192;
    localparam logic [8:0] H_PAPER_BEG = 9'd8;
    localparam logic [8:0] H_PAPER_END = 9'd263;
    localparam logic [8:0] V_PAPER_END = 9'd191;
    localparam logic [8:0] H_BLANK_BEG = 9'd320;
    localparam logic [8:0] H_BLANK_END = 9'd415;
    localparam logic [8:0] V_BLANK_BEG = 9'd240;
    localparam logic [8:0] V_BLANK_END = 9'd255;
    localparam logic [8:0] H_SYNC_BEG  = 9'd336;
    localparam logic [8:0] H_SYNC_END  = 9'd367;
    localparam logic [8:0] V_SYNC_BEG  = 9'd240;
    localparam logic [8:0] V_SYNC_END  = 9'd243;
    localparam logic [8:0] H_INT_BEG   = 9'd320;

    localparam logic [2:0] P_PIX  = 3'd2;
    localparam logic [2:0] P_ATTR = 3'd4;
    localparam logic [2:0] P_LOAD = 3'd7;

    localparam logic [3:0] ATTR_BASE = 4'b0110;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_PIX,
        SLOT_ATTR,
        SLOT_LOAD
    } slot_e;

    // Each 8-clock column: two pixel cycles, two attribute cycles, then the load.
    function automatic slot_e slot_of(input logic [2:0] p);
        slot_e s;
        s = SLOT_IDLE;
        if (p == P_PIX || p == P_PIX + 3'd1) begin
            s = SLOT_PIX;
        end else if (p == P_ATTR || p == P_ATTR + 3'd1) begin
            s = SLOT_ATTR;
        end else if (p == P_LOAD) begin
            s = SLOT_LOAD;
        end
        return s;
    endfunction

    function automatic logic [13:0] pix_addr(input logic [7:0] y, input logic [4:0] x);
        return {1'b0, y[7:6], y[2:0], y[5:3], x};
    endfunction

    function automatic logic [13:0] attr_addr(input logic [4:0] row, input logic [4:0] x);
        return {ATTR_BASE, row, x};
    endfunction

endpackage

// File: rtl/zx_video_sequencer_if.sv
// Video RAM port, fetch strobes and raster outputs of the sequencer.
interface zx_video_sequencer_if;
    logic        cpu_req;
    logic [13:0] va;
    logic        vrd;
    logic        cpu_gnt;
    logic        pix_stb;
    logic        attr_stb;
    logic        load;
    logic        border;
    logic        bl;
    logic        hsync;
    logic        vsync;
    logic        intr;
    logic        flash;

    modport master (
        input  cpu_req,
        output va, vrd, cpu_gnt, pix_stb, attr_stb, load,
        output border, bl, hsync, vsync, intr, flash
    );

    modport slave (
        output cpu_req,
        input  va, vrd, cpu_gnt, pix_stb, attr_stb, load,
        input  border, bl, hsync, vsync, intr, flash
    );
endinterface

// File: rtl/zx_video_sequencer_raster_counter.sv
// Horizontal/vertical/frame counters; exposes next-cycle positions so the
// top can register every output aligned with the counter value.
module zx_raster_counter #(
    parameter int H_TOTAL = zx_video_pkg::H_TOTAL,
    parameter int V_TOTAL = zx_video_pkg::V_TOTAL
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [8:0] hcnt_next_o,
    output logic [8:0] vcnt_next_o,
    output logic       flash_next_o
);
    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic [4:0] fcnt_q, fcnt_d;
    logic       h_wrap, v_wrap;

    always_comb begin
        h_wrap = (hcnt_q == 9'(H_TOTAL - 1));
        v_wrap = h_wrap && (vcnt_q == 9'(V_TOTAL - 1));
        hcnt_d = h_wrap ? 9'd0 : hcnt_q + 9'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? 9'd0 : vcnt_q + 9'd1;
        end
        fcnt_d = v_wrap ? fcnt_q + 5'd1 : fcnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign hcnt_next_o  = hcnt_d;
    assign vcnt_next_o  = vcnt_d;
    assign flash_next_o = fcnt_d[4];
endmodule

// File: rtl/zx_video_sequencer.sv
// Raster timing, video fetch sequencing and VRAM arbitration; every output
// is a flop loaded from the decode of the next counter position.
module zx_video_sequencer #(
    parameter int H_TOTAL  = zx_video_pkg::H_TOTAL,
    parameter int V_TOTAL  = zx_video_pkg::V_TOTAL,
    parameter int INT_LINE = zx_video_pkg::INT_LINE,
    parameter int INT_LEN  = zx_video_pkg::INT_LEN
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    zx_video_sequencer_if.master        vid
);
    import zx_video_pkg::*;

    localparam logic [8:0] H_INT_END = 9'(int'(H_INT_BEG) + INT_LEN - 1);

    logic [8:0]  hcnt_d, vcnt_d;
    logic        flash_d;
    slot_e       slot;
    logic [13:0] va_d, va_q;
    logic        vrd_d, vrd_q;
    logic        gnt_d, gnt_q;
    logic        pix_d, pix_q;
    logic        attr_d, attr_q;
    logic        load_d, load_q;
    logic        border_d, border_q;
    logic        bl_d, bl_q;
    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;
    logic        int_d, int_q;
    logic        flash_q;

    zx_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_raster (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hcnt_next_o  (hcnt_d),
        .vcnt_next_o  (vcnt_d),
        .flash_next_o (flash_d)
    );

    always_comb begin
        slot   = SLOT_IDLE;
        va_d   = '0;
        vrd_d  = 1'b0;
        pix_d  = 1'b0;
        attr_d = 1'b0;
        load_d = 1'b0;
        if (vcnt_d < V_FETCH_END && hcnt_d < H_FETCH_END) begin
            slot = slot_of(hcnt_d[2:0]);
        end
        case (slot)
            SLOT_PIX: begin
                vrd_d = 1'b1;
                va_d  = pix_addr(vcnt_d[7:0], hcnt_d[7:3]);
                pix_d = (hcnt_d[2:0] == P_PIX + 3'd1);
            end
            SLOT_ATTR: begin
                vrd_d  = 1'b1;
                va_d   = attr_addr(vcnt_d[7:3], hcnt_d[7:3]);
                attr_d = (hcnt_d[2:0] == P_ATTR + 3'd1);
            end
            SLOT_LOAD: load_d = 1'b1;
            default: ;
        endcase

        // The CPU only gets cycles the video fetch leaves untouched.
        gnt_d    = vid.cpu_req & ~vrd_d;
        border_d = !((hcnt_d >= H_PAPER_BEG) && (hcnt_d <= H_PAPER_END) &&
                     (vcnt_d <= V_PAPER_END));
        bl_d     = ((hcnt_d >= H_BLANK_BEG) && (hcnt_d <= H_BLANK_END)) ||
                   ((vcnt_d >= V_BLANK_BEG) && (vcnt_d <= V_BLANK_END));
        hsync_d  = (hcnt_d >= H_SYNC_BEG) && (hcnt_d <= H_SYNC_END);
        vsync_d  = (vcnt_d >= V_SYNC_BEG) && (vcnt_d <= V_SYNC_END);
        int_d    = (vcnt_d == 9'(INT_LINE)) && (hcnt_d >= H_INT_BEG) &&
                   (hcnt_d <= H_INT_END);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            va_q     <= '0;
            vrd_q    <= 1'b0;
            gnt_q    <= 1'b0;
            pix_q    <= 1'b0;
            attr_q   <= 1'b0;
            load_q   <= 1'b0;
            border_q <= 1'b1;
            bl_q     <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            int_q    <= 1'b0;
            flash_q  <= 1'b0;
        end else begin
            va_q     <= va_d;
            vrd_q    <= vrd_d;
            gnt_q    <= gnt_d;
            pix_q    <= pix_d;
            attr_q   <= attr_d;
            load_q   <= load_d;
            border_q <= border_d;
            bl_q     <= bl_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            int_q    <= int_d;
            flash_q  <= flash_d;
        end
    end

    assign vid.va       = va_q;
    assign vid.vrd      = vrd_q;
    assign vid.cpu_gnt  = gnt_q;
    assign vid.pix_stb  = pix_q;
    assign vid.attr_stb = attr_q;
    assign vid.load     = load_q;
    assign vid.border   = border_q;
    assign vid.bl       = bl_q;
    assign vid.hsync    = hsync_q;
    assign vid.vsync    = vsync_q;
    assign vid.intr     = int_q;
    assign vid.flash    = flash_q;
endmodule

// File: tb/tb_zx_video_sequencer.sv
// Directed bench: full-geometry instance for fetch/arbitration/reset, plus a
// two-line-frame instance for INT, frame wrap and FLASH within a short run.
module tb_zx_video_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   clk_no = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic released = 1'b0;
    logic small_done = 1'b0;

    localparam int HT = 448;
    localparam int SMALL_FRAME = 448 * 2;

    zx_video_sequencer_if vid ();
    zx_video_sequencer_if vid_s ();

    zx_video_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .vid   (vid)
    );

    zx_video_sequencer #(
        .V_TOTAL  (2),
        .INT_LINE (1)
    ) dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .vid   (vid_s)
    );

    always #5 clk = ~clk;

    // Clock index since the last reset release; sampled on the falling edge.
    always @(posedge clk or posedge rst) begin
        if (rst) clk_no <= 0;
        else     clk_no <= clk_no + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int target);
        while (clk_no < target) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " va"},       32'(vid.va), 32'h0);
        check_eq({tag, " vrd"},      32'(vid.vrd), 32'h0);
        check_eq({tag, " cpu_gnt"},  32'(vid.cpu_gnt), 32'h0);
        check_eq({tag, " pix_stb"},  32'(vid.pix_stb), 32'h0);
        check_eq({tag, " attr_stb"}, 32'(vid.attr_stb), 32'h0);
        check_eq({tag, " load"},     32'(vid.load), 32'h0);
        check_eq({tag, " border"},   32'(vid.border), 32'h1);
        check_eq({tag, " bl"},       32'(vid.bl), 32'h0);
        check_eq({tag, " hsync"},    32'(vid.hsync), 32'h0);
        check_eq({tag, " vsync"},    32'(vid.vsync), 32'h0);
        check_eq({tag, " int"},      32'(vid.intr), 32'h0);
        check_eq({tag, " flash"},    32'(vid.flash), 32'h0);
    endtask

    // First two columns of line 0 after release, CPU_REQ held high.
    task automatic check_line_start(input string tag);
        logic [15:0] vrd_e, pix_e, attr_e, load_e, bord_e, gnt_e;
        logic [13:0] va_e [16];
        vrd_e  = 16'h3C3C;
        pix_e  = 16'h0808;
        attr_e = 16'h2020;
        load_e = 16'h8080;
        bord_e = 16'h00FF;
        gnt_e  = 16'hC3C2;
        for (int c = 0; c < 16; c++) va_e[c] = 14'h0;
        va_e[4]  = 14'h1800;
        va_e[5]  = 14'h1800;
        va_e[10] = 14'h0001;
        va_e[11] = 14'h0001;
        va_e[12] = 14'h1801;
        va_e[13] = 14'h1801;
        for (int c = 0; c < 16; c++) begin
            wait_clk(c);
            check_eq($sformatf("%s vrd@%0d", tag, c),    32'(vid.vrd),      32'(vrd_e[c]));
            check_eq($sformatf("%s pix@%0d", tag, c),    32'(vid.pix_stb),  32'(pix_e[c]));
            check_eq($sformatf("%s attr@%0d", tag, c),   32'(vid.attr_stb), 32'(attr_e[c]));
            check_eq($sformatf("%s load@%0d", tag, c),   32'(vid.load),     32'(load_e[c]));
            check_eq($sformatf("%s border@%0d", tag, c), 32'(vid.border),   32'(bord_e[c]));
            check_eq($sformatf("%s gnt@%0d", tag, c),    32'(vid.cpu_gnt),  32'(gnt_e[c]));
            check_eq($sformatf("%s va@%0d", tag, c),     32'(vid.va),       32'(va_e[c]));
        end
    endtask

    // Main instance.
    initial begin
        int overlap, run, gaps, bad_gap, cont, bl_cnt, bl_first;
        int hs_cnt, hs_first, paper, pix_cnt;
        int l65, lr;
        overlap = 0; run = 0; gaps = 0; bad_gap = 0; cont = 0;
        bl_cnt = 0; bl_first = -1; hs_cnt = 0; hs_first = -1; paper = 0; pix_cnt = 0;

        vid.cpu_req   = 1'b1;
        vid_s.cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        @(negedge clk);
        rst = 1'b0;
        released = 1'b1;
        check_line_start("line0");

        for (int c = 16; c < HT; c++) begin
            wait_clk(c);
            if (vid.vrd && vid.cpu_gnt) overlap++;
            if (c < 256) begin
                if (!vid.cpu_gnt) run++;
                else if (run > 0) begin
                    gaps++;
                    if (run != 4) bad_gap++;
                    run = 0;
                end
            end else if (vid.cpu_gnt) cont++;
            if (vid.bl) begin bl_cnt++; if (bl_first < 0) bl_first = c; end
            if (vid.hsync) begin hs_cnt++; if (hs_first < 0) hs_first = c; end
            if (!vid.border) paper++;
            if (vid.pix_stb) pix_cnt++;
        end
        check_eq("gnt/vrd overlap", 32'(overlap), 32'd0);
        check_eq("gnt gaps", 32'(gaps), 32'd30);
        check_eq("gnt gaps not 4", 32'(bad_gap), 32'd0);
        check_eq("gnt cont 256-447", 32'(cont), 32'd192);
        check_eq("bl count", 32'(bl_cnt), 32'd96);
        check_eq("bl first", 32'(bl_first), 32'd320);
        check_eq("hsync count", 32'(hs_cnt), 32'd32);
        check_eq("hsync first", 32'(hs_first), 32'd336);
        check_eq("paper clocks", 32'(paper), 32'd248);
        check_eq("pix count", 32'(pix_cnt), 32'd30);

        l65 = 65 * HT;
        wait_clk(l65 + 251);
        check_eq("y65 x31 pix_stb", 32'(vid.pix_stb), 32'd1);
        check_eq("y65 x31 pix va", 32'(vid.va), 32'h091F);
        wait_clk(l65 + 253);
        check_eq("y65 x31 attr_stb", 32'(vid.attr_stb), 32'd1);
        check_eq("y65 x31 attr va", 32'(vid.va), 32'h191F);
        wait_clk(l65 + 255);
        check_eq("y65 x31 load", 32'(vid.load), 32'd1);
        wait_clk(l65 + 263);
        check_eq("y65 border@263", 32'(vid.border), 32'd0);
        wait_clk(l65 + 264);
        check_eq("y65 border@264", 32'(vid.border), 32'd1);
        check_eq("y65 vrd@264", 32'(vid.vrd), 32'd0);
        wait_clk(l65 + 335);
        check_eq("y65 hsync@335", 32'(vid.hsync), 32'd0);
        wait_clk(l65 + 336);
        check_eq("y65 hsync@336", 32'(vid.hsync), 32'd1);
        check_eq("y65 vsync", 32'(vid.vsync), 32'd0);
        check_eq("y65 int", 32'(vid.intr), 32'd0);

        lr = 100 * HT + 130;
        wait_clk(lr);
        check_eq("y100 h130 vrd", 32'(vid.vrd), 32'd1);
        check_eq("y100 h130 va", 32'(vid.va), 32'h0C90);
        check_eq("y100 h130 border", 32'(vid.border), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_vals("async rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_line_start("restart");

        check_eq("small instance done", 32'(small_done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Two-line-frame instance: INT placement, frame wrap and FLASH period.
    initial begin
        int int_cnt, int_first;
        int_cnt = 0;
        int_first = -1;
        wait (released);
        for (int c = 0; c < SMALL_FRAME; c++) begin
            wait_clk(c);
            if (vid_s.intr) begin
                int_cnt++;
                if (int_first < 0) int_first = c;
            end
        end
        check_eq("int length", 32'(int_cnt), 32'd32);
        check_eq("int start", 32'(int_first), 32'(HT + 320));
        wait_clk(SMALL_FRAME + 3);
        check_eq("wrap pix_stb", 32'(vid_s.pix_stb), 32'd1);
        check_eq("wrap va", 32'(vid_s.va), 32'h0000);
        wait_clk(16 * SMALL_FRAME - 1);
        check_eq("flash end f15", 32'(vid_s.flash), 32'd0);
        wait_clk(16 * SMALL_FRAME);
        check_eq("flash start f16", 32'(vid_s.flash), 32'd1);
        wait_clk(32 * SMALL_FRAME - 1);
        check_eq("flash end f31", 32'(vid_s.flash), 32'd1);
        wait_clk(32 * SMALL_FRAME);
        check_eq("flash start f32", 32'(vid_s.flash), 32'd0);
        small_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
